// File: rtl/simon_pkg.sv
// Shared parameters and the per-path state type for the SIMON byte loader.
//   N          : cipher word width in bits
//   M          : key words per key
//   BLK_BYTES  : bytes per data block (two words)
//   KEY_BYTES  : bytes per key (M words)
//   path_state_e : FILL (collecting bytes) / FULL (block held, awaiting issue)
package simon_pkg;

    localparam int unsigned N         = 32;
    localparam int unsigned M         = 3;
    localparam int unsigned BLK_BYTES = 2 * N / 8;
    localparam int unsigned KEY_BYTES = M * N / 8;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } path_state_e;

endpackage

// File: rtl/simon_byte_assembler.sv
// One byte-assembly path: counts accepted bytes, shifts them into a
// big-endian buffer (first byte ends up in the MSBs) and holds FULL until
// the owner issues the block.
//   clk, nR  : clock, async active-low reset
//   accept   : a byte for this path is taken this cycle
//   byte_in  : the byte
//   issue    : block is being copied out this cycle (only honoured in FULL)
//   full     : path holds a complete block
//   shift_q  : assembly buffer
module simon_byte_assembler
    import simon_pkg::*;
#(
    parameter int unsigned BYTES = 8
) (
    input  logic                 clk,
    input  logic                 nR,
    input  logic                 accept,
    input  logic [7:0]           byte_in,
    input  logic                 issue,
    output logic                 full,
    output logic [BYTES*8-1:0]   shift_q
);

    localparam int unsigned CW   = $clog2(BYTES);
    localparam int unsigned W    = BYTES * 8;
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

    path_state_e   state_q;
    path_state_e   state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [W-1:0]  shift_d;

    // State, counter and buffer registers
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state_q <= FILL;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // Next-state: last byte moves to FULL and wraps the counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    shift_d = {shift_q[W-9:0], byte_in};
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = FULL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FULL: begin
                if (issue) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign full = (state_q == FULL);

endmodule

// File: rtl/simon_byte_loader.sv
// Byte-serial front end for a SIMON core: splits an 8-bit stream into a
// data path and a key path, assembles each into a full block, and issues
// blocks to the core with one-cycle pulses. Key issue wins a same-cycle tie.
//   clk, nR               : clock, async active-low reset
//   in_valid/in_byte      : upstream byte
//   in_is_key             : 1 = key stream, 0 = data stream
//   in_enc_dec            : direction, taken with the data bytes
//   in_ready              : combinational, per-stream backpressure
//   loadData/loadKey      : core can accept a block / key
//   newData/newKey        : registered one-cycle issue pulses
//   inData/key/enc_dec    : registered issued values, held between pulses
module simon_byte_loader #(
    parameter int unsigned N = simon_pkg::N,
    parameter int unsigned M = simon_pkg::M
) (
    input  logic                  clk,
    input  logic                  nR,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    input  logic                  in_is_key,
    input  logic                  in_enc_dec,
    output logic                  in_ready,
    input  logic                  loadData,
    input  logic                  loadKey,
    output logic                  newData,
    output logic                  newKey,
    output logic [1:0][N-1:0]     inData,
    output logic [M-1:0][N-1:0]   key,
    output logic                  enc_dec
);

    localparam int unsigned BLK_B = 2 * N / 8;
    localparam int unsigned KEY_B = M * N / 8;

    logic               data_full;
    logic               key_full;
    logic [2*N-1:0]     data_buf;
    logic [M*N-1:0]     key_buf;
    logic               data_acc;
    logic               key_acc;
    logic               data_issue;
    logic               key_issue;
    logic               ed_hold;

    // Each stream is only stalled by its own path
    assign in_ready   = in_is_key ? !key_full : !data_full;
    assign data_acc   = in_valid && in_ready && !in_is_key;
    assign key_acc    = in_valid && in_ready &&  in_is_key;

    // Key has priority; a deferred data issue simply retries next cycle
    assign key_issue  = key_full && loadKey;
    assign data_issue = data_full && loadData && !key_issue;

    simon_byte_assembler #(.BYTES(BLK_B)) u_data_asm (
        .clk     (clk),
        .nR      (nR),
        .accept  (data_acc),
        .byte_in (in_byte),
        .issue   (data_issue),
        .full    (data_full),
        .shift_q (data_buf)
    );

    simon_byte_assembler #(.BYTES(KEY_B)) u_key_asm (
        .clk     (clk),
        .nR      (nR),
        .accept  (key_acc),
        .byte_in (in_byte),
        .issue   (key_issue),
        .full    (key_full),
        .shift_q (key_buf)
    );

    // Direction of the block being assembled; the last data byte's value sticks
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            ed_hold <= 1'b0;
        end else if (data_acc) begin
            ed_hold <= in_enc_dec;
        end
    end

    // Output registers: values only move on the edge that raises their pulse
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            newData <= 1'b0;
            newKey  <= 1'b0;
            inData  <= '0;
            key     <= '0;
            enc_dec <= 1'b0;
        end else begin
            newData <= data_issue;
            newKey  <= key_issue;
            if (key_issue) begin
                key <= key_buf;
            end
            if (data_issue) begin
                inData  <= data_buf;
                enc_dec <= ed_hold;
            end
        end
    end

endmodule

// File: tb/tb_simon_byte_loader.sv
// Self-checking bench for simon_byte_loader: directed table, multi-cycle
// corner sequences and randomized traffic against a byte-queue model.
module tb_simon_byte_loader;

    localparam int unsigned N  = 32;
    localparam int unsigned M  = 3;
    localparam int unsigned BB = 8;
    localparam int unsigned KB = 12;

    logic                 clk = 1'b0;
    logic                 nR;
    logic                 in_valid;
    logic [7:0]           in_byte;
    logic                 in_is_key;
    logic                 in_enc_dec;
    logic                 in_ready;
    logic                 loadData;
    logic                 loadKey;
    logic                 newData;
    logic                 newKey;
    logic [1:0][N-1:0]    inData;
    logic [M-1:0][N-1:0]  key;
    logic                 enc_dec;

    always #5 clk = ~clk;

    simon_byte_loader #(.N(N), .M(M)) dut (
        .clk        (clk),
        .nR         (nR),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_is_key  (in_is_key),
        .in_enc_dec (in_enc_dec),
        .in_ready   (in_ready),
        .loadData   (loadData),
        .loadKey    (loadKey),
        .newData    (newData),
        .newKey     (newKey),
        .inData     (inData),
        .key        (key),
        .enc_dec    (enc_dec)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    // ---------------- reference model: byte queues per stream ----------------
    logic [7:0]  dq[$];
    logic [7:0]  kq[$];
    bit          m_dfull, m_kfull, m_nd, m_nk, m_ed, m_edl;
    logic [63:0] m_data;
    logic [95:0] m_key;

    function automatic logic [95:0] pack_q(input logic [7:0] q[$]);
        logic [95:0] r = '0;
        foreach (q[i]) r = (r << 8) | 96'(q[i]);
        return r;
    endfunction

    task automatic model_reset();
        dq.delete(); kq.delete();
        m_dfull = 0; m_kfull = 0; m_nd = 0; m_nk = 0; m_ed = 0; m_edl = 0;
        m_data = '0; m_key = '0;
    endtask

    // One clock: drive, check in_ready, clock, advance model, check outputs
    task automatic cyc(input bit v, input bit k, input logic [7:0] b,
                       input bit ed, input bit ld, input bit lk);
        bit rdy, acc, kiss, diss;
        in_valid = v; in_is_key = k; in_byte = b; in_enc_dec = ed;
        loadData = ld; loadKey = lk;
        #1;
        rdy = k ? !m_kfull : !m_dfull;
        chk("in_ready", 128'(in_ready), 128'(rdy));
        acc  = v && rdy;
        kiss = m_kfull && lk;
        diss = m_dfull && ld && !kiss;
        @(posedge clk); #1;
        m_nk = kiss; m_nd = diss;
        if (kiss) begin m_key = pack_q(kq); kq.delete(); m_kfull = 0; end
        if (diss) begin m_data = 64'(pack_q(dq)); m_ed = m_edl; dq.delete(); m_dfull = 0; end
        if (acc) begin
            if (k) begin
                kq.push_back(b);
                if (kq.size() == KB) m_kfull = 1;
            end else begin
                dq.push_back(b);
                m_edl = ed;
                if (dq.size() == BB) m_dfull = 1;
            end
        end
        chk("newKey",  128'(newKey),  128'(m_nk));
        chk("newData", 128'(newData), 128'(m_nd));
        chk("key",     128'(key),     128'(m_key));
        chk("inData",  128'(inData),  128'(m_data));
        chk("enc_dec", 128'(enc_dec), 128'(m_ed));
    endtask

    task automatic do_reset();
        in_valid = 0; loadData = 0; loadKey = 0; in_is_key = 0;
        nR = 0;
        #1;
        chk("rst newData", 128'(newData), 128'(0));
        chk("rst newKey",  128'(newKey),  128'(0));
        chk("rst inData",  128'(inData),  128'(0));
        chk("rst key",     128'(key),     128'(0));
        chk("rst enc_dec", 128'(enc_dec), 128'(0));
        chk("rst ready d", 128'(in_ready), 128'(1));
        in_is_key = 1; #1;
        chk("rst ready k", 128'(in_ready), 128'(1));
        in_is_key = 0;
        model_reset();
        @(posedge clk); #1;
        nR = 1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit           is_key;
        int           n;
        logic [7:0]   b [0:11];
        bit           ed;
        logic [95:0]  exp_val;
        bit           exp_ed;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int pulses;
        logic [95:0] got;
        bit got_ed;
        logic [7:0] kb [12];
        logic [7:0] db [8];
        logic [95:0] ek;
        logic [63:0] ed64;

        tbl[0] = '{1, 12, '{8'h13,8'h12,8'h11,8'h10,8'h0b,8'h0a,8'h09,8'h08,8'h03,8'h02,8'h01,8'h00},
                   0, 96'h13121110_0b0a0908_03020100, 0};
        tbl[1] = '{0, 8,  '{8'h6f,8'h72,8'h20,8'h67,8'h6e,8'h69,8'h63,8'h6c,0,0,0,0},
                   1, 96'h6f722067_6e69636c, 1};
        tbl[2] = '{0, 8,  '{8'h01,8'h23,8'h45,8'h67,8'h89,8'hab,8'hcd,8'hef,0,0,0,0},
                   0, 96'h01234567_89abcdef, 0};
        tbl[3] = '{1, 12, '{8'hff,8'h00,8'hee,8'h11,8'hdd,8'h22,8'hcc,8'h33,8'hbb,8'h44,8'haa,8'h55},
                   0, 96'hff00ee11_dd22cc33_bb44aa55, 0};

        nR = 0; in_valid = 0; in_byte = 0; in_is_key = 0; in_enc_dec = 0;
        loadData = 0; loadKey = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Table: one block per entry, expect exactly one pulse with the listed value
        for (int t = 0; t < 4; t++) begin
            pulses = 0; got = '0; got_ed = 0;
            for (int i = 0; i < tbl[t].n; i++) begin
                cyc(1, tbl[t].is_key, tbl[t].b[i], (i == tbl[t].n - 1) ? tbl[t].ed : 1'b0, 1, 1);
                if (tbl[t].is_key ? newKey : newData) pulses++;
            end
            for (int i = 0; i < 5; i++) begin
                cyc(0, 0, 8'h00, 0, 1, 1);
                if (tbl[t].is_key && newKey) begin pulses++; got = 96'(key); end
                if (!tbl[t].is_key && newData) begin pulses++; got = 96'(inData); got_ed = enc_dec; end
            end
            chk($sformatf("tbl%0d pulses", t), 128'(pulses), 128'(1));
            chk($sformatf("tbl%0d value", t), 128'(got), 128'(tbl[t].exp_val));
            if (!tbl[t].is_key) chk($sformatf("tbl%0d enc_dec", t), 128'(got_ed), 128'(tbl[t].exp_ed));
        end

        // Interleaved streams, both full together: key issues, data next cycle
        foreach (kb[i]) kb[i] = 8'($urandom);
        foreach (db[i]) db[i] = 8'($urandom);
        ek = '0; ed64 = '0;
        foreach (kb[i]) ek = ek + (96'(kb[i]) << (8 * (11 - i)));
        foreach (db[i]) ed64 = ed64 + (64'(db[i]) << (8 * (7 - i)));
        for (int i = 0; i < 12; i++) begin
            cyc(1, 1, kb[i], 0, 0, 1);
            if (i < 8) cyc(1, 0, db[i], (i == 7), 0, 1);
        end
        cyc(0, 0, 8'h00, 0, 1, 1);
        chk("tie newKey",  128'(newKey),  128'(1));
        chk("tie newData0", 128'(newData), 128'(0));
        chk("tie key",     128'(key),     128'(ek));
        cyc(0, 0, 8'h00, 0, 1, 1);
        chk("tie newData1", 128'(newData), 128'(1));
        chk("tie newKey1",  128'(newKey),  128'(0));
        chk("tie inData",  128'(inData),  128'(ed64));
        chk("tie enc_dec", 128'(enc_dec), 128'(1));

        // Data held FULL with loadData low: only data stream is stalled
        for (int i = 0; i < 8; i++) cyc(1, 0, 8'(8'h40 + i), 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            in_is_key = 0; #1;
            chk("hold ready d", 128'(in_ready), 128'(0));
            in_is_key = 1; #1;
            chk("hold ready k", 128'(in_ready), 128'(1));
            cyc(0, i[0], 8'h00, 0, 0, 0);
            chk("hold newData", 128'(newData), 128'(0));
        end
        cyc(0, 0, 8'h00, 0, 1, 0);
        chk("hold release", 128'(newData), 128'(1));
        chk("hold inData", 128'(inData), 128'h4041424344454647);

        // Reset mid-assembly discards partial bytes
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'hd0 + i), 1, 0, 0);
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 0, 8'(8'ha0 + i), 0, 1, 0);
        cyc(0, 0, 8'h00, 0, 1, 0);
        chk("rst fresh pulse", 128'(newData), 128'(1));
        chk("rst fresh data", 128'(inData), 128'ha0a1a2a3a4a5a6a7);
        chk("rst fresh ed", 128'(enc_dec), 128'(0));

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cyc(bit'($urandom_range(0, 3) != 0), bit'($urandom), 8'($urandom),
                bit'($urandom), bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
